inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Program loader: the producer-side counterpart of the core's instruction decoder.
- Accepts assembly-level fields (opcode, s1, s2, s3, immediate) over a valid/ready handshake.
- Packs each instruction into a 32-bit word using the same R/I-type field layout the decoder unpacks.
- Writes words sequentially into instruction memory, so bench/boot logic can load programs without hand-encoding.

Parameters:
- INST_W, 32, instruction word width (fixed layout, must be 32)
- ADDR_W, 32, instruction memory byte-address width
- DEPTH, 1024, maximum number of instructions per program
- ADDR_STEP, 4, byte increment between consecutive instruction addresses

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  begin a new program load; count and error cleared
- i_valid  in  1  field bundle valid
- o_ready  out  1  encoder accepts a bundle this cycle
- i_opcode  in  6  opcode
- i_s1  in  5  R-type destination register (ignored for I-type)
- i_s2  in  5  source register 1
- i_s3  in  5  source register 2 / I-type destination
- i_im  in  16  I-type immediate (ignored for R-type)
- i_last  in  1  bundle is the final instruction of the program
- o_i_wen  out  1  instruction memory write strobe
- o_i_addr  out  ADDR_W  write byte address
- o_i_wdata  out  INST_W  encoded instruction word
- o_count  out  $clog2(DEPTH)+1  instructions written so far
- o_done  out  1  load completed (level)
- o_err  out  2  00 none, 01 illegal opcode, 10 overflow

Behaviour:
- Reset: state IDLE; o_ready, o_i_wen, o_done = 0; o_i_addr, o_i_wdata, o_count, o_err = 0. Any pending write is dropped.
- FSM states: IDLE, LOAD, DONE, ERR.
  - Any state + i_start -> LOAD; count=0, err=00, o_done=0.
  - i_start has priority over a concurrent handshake; o_ready is 0 in the i_start cycle.
- o_ready = 1 only in LOAD; it is a registered function of state.
- Handshake: accept when i_valid && o_ready. i_valid without o_ready is ignored; the producer must hold the bundle.
- Type classification:
  - R-type opcodes: 0, 1, 2, 3, 7, 8, 9, 12, 13, 14.
  - Legal I-type opcodes: 4, 5, 6, 10, 11, 15, 16.
  - Opcode > 16 is illegal.
- Encoding:
  - R-type word = {opcode, s2, s3, s1, 11'b0}.
  - I-type word = {opcode, s2, s3, im}.
  - Decoding the word reproduces opcode, s2, s3, and s1 (R) or im (I).
- Write timing, latency 1:
  - The cycle after acceptance: o_i_wen=1 for exactly one cycle, o_i_wdata=word, o_i_addr=count*ADDR_STEP (pre-increment), then count++.
  - Memory accepts a write every cycle, so there is no back-pressure.
  - Back-to-back accepts produce back-to-back writes.
- i_last accepted: the word is written as normal and state -> DONE. o_done rises in the same cycle as that write and holds until i_start.
- Illegal opcode accepted: no write; o_err=01; state -> ERR. Previously written words remain.
- Overflow: a bundle accepted while count==DEPTH is not written; o_err=10; state -> ERR.
- Boundary: the write at count==DEPTH-1 succeeds, including when it carries i_last. o_count saturates at DEPTH.
- o_err holds until i_start or reset. Inputs are ignored in IDLE, DONE and ERR.
- Address arithmetic: count*ADDR_STEP truncated to ADDR_W bits, with no wrap check beyond DEPTH.

Decomposition:
- Shared package `inst_pkg`, also imported by the decoder:
  - opcode localparams
  - field bit positions: OPC 31:26, S2 25:21, S3 20:16, S1 15:11, IM 15:0
  - R-type opcode set
  - OPC_MAX=16
  - error code constants
- Sub-module `inst_type_lut`: combinational opcode -> {is_r_type, legal}, shared with the decoder so classification cannot diverge.
- FSM, counter and write register stay in inst_encoder.

Test Plan:
- R-type: i_start, then opcode=1, s2=3, s3=4, s1=5 -> next cycle o_i_wen=1, o_i_addr=0x0, o_i_wdata=0x04642800, o_count=1.
- I-type: opcode=4, s2=1, s3=2, im=0xFFFC, s1=7 -> o_i_wdata=0x1022FFFC, and s1 does not appear in the word.
- Back-to-back load of 3 words, last with i_last:
  - three consecutive o_i_wen pulses at addresses 0x0, 0x4, 0x8;
  - o_done=1 with the third write;
  - o_ready=0 afterwards and o_count=3.
- Illegal opcode 6'd20 after 2 valid words -> no write, o_err=01, o_ready=0; a following i_start clears o_err and o_count and restores o_ready=1.
- DEPTH=4 overflow:
  - 4 words without i_last, then a 5th -> 5th not written, o_err=10, o_count=4;
  - separately, a 4th word carrying i_last -> o_done=1 and o_err=00.
- Async reset asserted in the cycle after acceptance -> o_i_wen stays 0 (write dropped), all outputs 0, state IDLE; i_start while i_valid=1 -> bundle not accepted that cycle.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared definitions for the instruction encoder and decoder: field layout,
// opcode classification sets, error codes and the word-packing helper.
package inst_pkg;

    localparam int OPC_W  = 6;
    localparam int REG_W  = 5;
    localparam int IM_W   = 16;
    localparam int WORD_W = 32;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int S2_HI  = 25;
    localparam int S2_LO  = 21;
    localparam int S3_HI  = 20;
    localparam int S3_LO  = 16;
    localparam int S1_HI  = 15;
    localparam int S1_LO  = 11;
    localparam int IM_HI  = 15;
    localparam int IM_LO  = 0;

    localparam logic [OPC_W-1:0] OPC_MAX = 6'd16;

    // Bit n set means opcode n is R-type: 0-3, 7-9, 12-14.
    localparam logic [31:0] R_TYPE_SET = 32'h0000_738F;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_OVERFLOW = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic [WORD_W-1:0] encode_word(
        input logic             is_r,
        input logic [OPC_W-1:0] opc,
        input logic [REG_W-1:0] s1,
        input logic [REG_W-1:0] s2,
        input logic [REG_W-1:0] s3,
        input logic [IM_W-1:0]  im
    );
        logic [WORD_W-1:0] word;
        word                = '0;
        word[OPC_HI:OPC_LO] = opc;
        word[S2_HI:S2_LO]   = s2;
        word[S3_HI:S3_LO]   = s3;
        if (is_r) begin
            word[S1_HI:S1_LO] = s1;
        end else begin
            word[IM_HI:IM_LO] = im;
        end
        return word;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle handshake between a program producer (master) and the encoder (slave).
interface inst_encoder_if;
    import inst_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [OPC_W-1:0] i_opcode;
    logic [REG_W-1:0] i_s1;
    logic [REG_W-1:0] i_s2;
    logic [REG_W-1:0] i_s3;
    logic [IM_W-1:0]  i_im;
    logic             i_last;

    modport master (
        output i_valid, i_opcode, i_s1, i_s2, i_s3, i_im, i_last,
        input  o_ready
    );

    modport slave (
        input  i_valid, i_opcode, i_s1, i_s2, i_s3, i_im, i_last,
        output o_ready
    );

endinterface

// File: rtl/inst_type_lut.sv
// Opcode classification shared by encoder and decoder so both agree on
// which opcodes are R-type and which are legal at all.
module inst_type_lut
    import inst_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic             is_r_type_o,
    output logic             legal_o
);

    assign legal_o     = (opcode_i <= OPC_MAX);
    // Index wraps for opcodes >= 32, but those are masked by legal_o.
    assign is_r_type_o = legal_o & R_TYPE_SET[opcode_i[4:0]];

endmodule

// File: rtl/inst_encoder.sv
// Program loader: packs assembly-level fields into R/I-type words and writes
// them to sequential instruction-memory addresses, one cycle after acceptance.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_STEP = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    inst_encoder_if.slave          bus,
    output logic                   o_i_wen,
    output logic [ADDR_W-1:0]      o_i_addr,
    output logic [INST_W-1:0]      o_i_wdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_done,
    output logic [1:0]             o_err
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INST_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    err_e               err_q, err_d;

    logic               is_r_type;
    logic               legal;
    logic               accept;
    logic               full;
    logic [ADDR_W-1:0]  wr_addr;

    inst_type_lut u_lut (
        .opcode_i    (bus.i_opcode),
        .is_r_type_o (is_r_type),
        .legal_o     (legal)
    );

    // i_start wins over a concurrent handshake, so it masks ready in its own cycle.
    assign bus.o_ready = ready_q & ~i_start;
    assign accept      = bus.i_valid & bus.o_ready;
    assign full        = (count_q == CNT_FULL);
    assign wr_addr     = ADDR_W'(count_q) * ADDR_W'(ADDR_STEP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = ST_LOAD;
        end else if (accept) begin
            if (!legal || full) begin
                state_d = ST_ERR;
            end else if (bus.i_last) begin
                state_d = ST_DONE;
            end
        end
    end

    always_comb begin
        ready_d = (state_d == ST_LOAD);
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        if (i_start) begin
            count_d = '0;
            done_d  = 1'b0;
            err_d   = ERR_NONE;
        end else if (accept) begin
            if (!legal) begin
                err_d = ERR_ILLEGAL;
            end else if (full) begin
                err_d = ERR_OVERFLOW;
            end else begin
                wen_d   = 1'b1;
                addr_d  = wr_addr;
                wdata_d = INST_W'(encode_word(is_r_type, bus.i_opcode, bus.i_s1,
                                              bus.i_s2, bus.i_s3, bus.i_im));
                count_d = count_q + CNT_W'(1);
                if (bus.i_last) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    assign o_i_wen   = wen_q;
    assign o_i_addr  = addr_q;
    assign o_i_wdata = wdata_q;
    assign o_count   = count_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed cases plus random programs,
// checked against a field-level reference model of the loader.
module tb_inst_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int STEP   = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] wdata;
    logic [CW-1:0]     count;
    logic              done;
    logic [1:0]        err;

    inst_encoder_if bus ();

    inst_encoder #(
        .INST_W    (INST_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .ADDR_STEP (STEP)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .bus       (bus),
        .o_i_wen   (wen),
        .o_i_addr  (addr),
        .o_i_wdata (wdata),
        .o_count   (count),
        .o_done    (done),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] word;
        int          count;
        bit          done;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    // Reference model state
    bit   m_load  = 0;
    int   m_count = 0;
    bit   m_done  = 0;
    logic [1:0] m_err = 2'b00;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int opc, input int s1, input int s2,
                                             input int s3, input int im);
        bit is_r;
        int w;
        is_r = opc inside {0, 1, 2, 3, 7, 8, 9, 12, 13, 14};
        w = opc * (1 << 26) + s2 * (1 << 21) + s3 * (1 << 16) + (is_r ? s1 * (1 << 11) : im);
        return 32'(w);
    endfunction

    task automatic model_accept(input int opc, input int s1, input int s2, input int s3,
                                input int im, input bit last);
        wr_t w;
        if (opc > 16) begin
            m_err  = 2'b01;
            m_load = 0;
        end else if (m_count == DEPTH) begin
            m_err  = 2'b10;
            m_load = 0;
        end else begin
            w.cyc   = cyc + 1;
            w.addr  = 32'(m_count * STEP);
            w.word  = ref_word(opc, s1, s2, s3, im);
            m_count = m_count + 1;
            w.count = m_count;
            w.done  = last;
            if (last) begin
                m_done = 1;
                m_load = 0;
            end
            sb.push_back(w);
        end
    endtask

    task automatic check_status();
        chk("ready", bus.o_ready, (m_load && !start));
        chk("count", count, m_count);
        chk("done",  done,  m_done);
        chk("err",   err,   m_err);
    endtask

    task automatic send(input int opc, input int s1, input int s2, input int s3,
                        input int im, input bit last);
        bus.i_valid  = 1'b1;
        bus.i_opcode = 6'(opc);
        bus.i_s1     = 5'(s1);
        bus.i_s2     = 5'(s2);
        bus.i_s3     = 5'(s3);
        bus.i_im     = 16'(im);
        bus.i_last   = last;
        @(negedge clk);
        check_status();
        if (m_load && !start) model_accept(opc, s1, s2, s3, im, last);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_status();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        check_status();
        @(posedge clk);
        #1;
        start   = 1'b0;
        m_load  = 1;
        m_count = 0;
        m_err   = 2'b00;
        m_done  = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wen"},   wen,   0);
        chk({tag, "_addr"},  addr,  0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_done"},  done,  0);
        chk({tag, "_err"},   err,   0);
        chk({tag, "_ready"}, bus.o_ready, 0);
    endtask

    // Monitor: every scheduled write must appear in exactly its cycle.
    always @(negedge clk) begin
        wr_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            $display("write cyc=%0d addr=%h data=%h count=%0d done=%0d", cyc, addr, wdata, count, done);
            chk("wr_strobe", wen, 1);
            chk("wr_addr",   addr, e.addr);
            chk("wr_data",   wdata, e.word);
            chk("wr_count",  count, e.count);
            chk("wr_done",   done, e.done);
        end else if (wen === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual=addr %h data %h required=no write", addr, wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, opc;
        bit last;
        bus.i_valid = 1'b0; bus.i_opcode = '0; bus.i_s1 = '0; bus.i_s2 = '0;
        bus.i_s3 = '0; bus.i_im = '0; bus.i_last = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // R-type then I-type words
        do_start();
        send(1, 5, 3, 4, 16'h1234, 0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        check_status();
        chk("r_word", wdata, 32'h0464_2800);
        chk("r_addr", addr, 0);
        @(posedge clk); #1;
        send(4, 7, 1, 2, 16'hFFFC, 0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        check_status();
        chk("i_word", wdata, 32'h1022_FFFC);
        @(posedge clk); #1;

        // Back-to-back 3-word program
        do_start();
        send(2, 1, 2, 3, 0, 0);
        send(5, 4, 5, 6, 16'h00AA, 0);
        send(13, 7, 8, 9, 0, 1);
        idle(2);

        // Illegal opcode after two good words, then restart
        do_start();
        send(0, 1, 1, 1, 0, 0);
        send(16, 2, 2, 2, 16'h8000, 0);
        send(20, 3, 3, 3, 16'h0001, 0);
        idle(2);
        do_start();
        idle(1);

        // Overflow: fifth word into a full program
        do_start();
        for (int i = 0; i < 5; i++) send(i, i, i + 1, i + 2, i * 3, 0);
        idle(2);

        // Last word exactly at capacity
        do_start();
        for (int i = 0; i < 4; i++) send(6 + i, i, i, i, 16'h0100 + i, (i == 3));
        idle(2);

        // Async reset before the pending write edge drops the write
        do_start();
        bus.i_valid = 1'b1; bus.i_opcode = 6'd3; bus.i_last = 1'b0;
        @(negedge clk);
        check_status();
        rst_n  = 1'b0;
        m_load = 0; m_count = 0; m_done = 0; m_err = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start();
        idle(1);

        // Random programs
        for (int p = 0; p < 60; p++) begin
            bus.i_valid = ($urandom_range(0, 3) == 0);
            do_start();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                opc  = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 63) : $urandom_range(0, 16);
                last = (i == len - 1) && ($urandom_range(0, 2) != 0);
                send(opc, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), last);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            idle(1);
        end

        idle(3);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
